// File: rtl/conv_core_v2.sv
// conv_core_v2: 1-D linear convolution core. Z[k] = sum X[i]*Y[k-i].
// Ports: X/Y sync-read RAM ports, Z write port, start/config_in, status.
module conv_core_v2 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZW         = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [2*ADDR_WIDTH+1:0]   config_in,
  input  logic [DATA_WIDTH-1:0]     dataX,
  output logic [ADDR_WIDTH-1:0]     memX_addr,
  input  logic [DATA_WIDTH-1:0]     dataY,
  output logic [ADDR_WIDTH-1:0]     memY_addr,
  output logic [ZW-1:0]             dataZ,
  output logic [ADDR_WIDTH:0]       memZ_addr,
  output logic                      writeZ,
  output logic                      busy_out,
  output logic                      done_out,
  output logic                      ovf_out,
  output logic                      err_out
);

  localparam int DW    = DATA_WIDTH;
  localparam int AW    = ADDR_WIDTH;
  localparam int KW    = AW + 1;
  localparam int PW    = 2*DW + 2;
  localparam int ACC_W = 2*DW + AW;
  localparam int EW    = ((ACC_W > ZW) ? ACC_W : ZW) + 1;

  typedef enum logic [2:0] {
    IDLE, SETUP, ISSUE, DRAIN1, DRAIN2, WRITE, DONE
  } state_t;

  state_t            state_q;
  logic [AW-1:0]     sx_q, sy_q;
  logic              sgn_q, sat_q;
  logic [KW-1:0]     k_q;
  logic [AW-1:0]     xa_q, ya_q;
  logic              v1_q, v2_q;
  logic [PW-1:0]     prod_q;
  logic [ACC_W-1:0]  acc_q;
  logic [ZW-1:0]     dz_q;
  logic [KW-1:0]     za_q;
  logic              wz_q, busy_q, done_q, ovf_q, err_q;

  // Operands widened by one bit so one signed multiplier
  // covers both modes.
  logic signed [DW:0]   xo, yo;
  logic signed [PW-1:0] prod_c;

  assign xo     = {sgn_q & dataX[DW-1], dataX};
  assign yo     = {sgn_q & dataY[DW-1], dataY};
  assign prod_c = PW'(xo) * PW'(yo);

  logic [ACC_W-1:0] acc_n;
  assign acc_n = acc_q +
    {{(ACC_W-PW){prod_q[PW-1]}}, prod_q};

  logic [EW-1:0] ext;
  logic          ovf_c;
  logic [ZW-1:0] sat_v, dz_c;

  assign ext = {{(EW-ACC_W){sgn_q & acc_n[ACC_W-1]}}, acc_n};

  always_comb begin
    ovf_c = 1'b0;
    sat_v = '1;
    if (sgn_q) begin
      ovf_c = !((&ext[EW-1:ZW-1]) || !(|ext[EW-1:ZW-1]));
      sat_v = ext[EW-1] ? {1'b1, {(ZW-1){1'b0}}}
                        : {1'b0, {(ZW-1){1'b1}}};
    end else begin
      ovf_c = |ext[EW-1:ZW];
    end
    dz_c = (sat_q && ovf_c) ? sat_v : ext[ZW-1:0];
  end

  // Loop bookkeeping for the next output index.
  logic [KW-1:0] kn_c, klast_c;
  logic [AW-1:0] lo_c, yn_c;
  logic          last_c, zero_c;

  always_comb begin
    kn_c    = k_q + KW'(1);
    klast_c = KW'(sx_q) + KW'(sy_q) - KW'(2);
    lo_c    = '0;
    if (kn_c >= KW'(sy_q))
      lo_c = AW'(kn_c - KW'(sy_q) + KW'(1));
    yn_c    = AW'(kn_c - KW'(lo_c));
    // i stops at min(k, sizeX-1), whichever it hits first
    last_c  = (KW'(xa_q) == k_q) ||
              (xa_q == sx_q - AW'(1));
    zero_c  = (config_in[AW-1:0] == '0) ||
              (config_in[2*AW-1:AW] == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sx_q    <= '0;
      sy_q    <= '0;
      sgn_q   <= 1'b0;
      sat_q   <= 1'b0;
      k_q     <= '0;
      xa_q    <= '0;
      ya_q    <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      prod_q  <= '0;
      acc_q   <= '0;
      dz_q    <= '0;
      za_q    <= '0;
      wz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      v1_q   <= (state_q == ISSUE);
      v2_q   <= v1_q;
      prod_q <= prod_c;
      if (v2_q)
        acc_q <= acc_n;
      wz_q   <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SETUP;
            busy_q  <= 1'b1;
          end
        end
        SETUP: begin
          sx_q  <= config_in[AW-1:0];
          sy_q  <= config_in[2*AW-1:AW];
          sgn_q <= config_in[2*AW];
          sat_q <= config_in[2*AW+1];
          ovf_q <= 1'b0;
          err_q <= zero_c;
          k_q   <= '0;
          if (zero_c) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= ISSUE;
            xa_q    <= '0;
            ya_q    <= '0;
            acc_q   <= '0;
          end
        end
        ISSUE: begin
          if (last_c) begin
            state_q <= DRAIN1;
            xa_q    <= '0;
            ya_q    <= '0;
          end else begin
            xa_q <= xa_q + AW'(1);
            ya_q <= ya_q - AW'(1);
          end
        end
        DRAIN1: state_q <= DRAIN2;
        DRAIN2: begin
          state_q <= WRITE;
          wz_q    <= 1'b1;
          za_q    <= k_q;
          dz_q    <= dz_c;
          if (ovf_c)
            ovf_q <= 1'b1;
        end
        WRITE: begin
          if (k_q == klast_c) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= ISSUE;
            k_q     <= kn_c;
            xa_q    <= lo_c;
            ya_q    <= yn_c;
            acc_q   <= '0;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign memX_addr = xa_q;
  assign memY_addr = ya_q;
  assign dataZ     = dz_q;
  assign memZ_addr = za_q;
  assign writeZ    = wz_q;
  assign busy_out  = busy_q;
  assign done_out  = done_q;
  assign ovf_out   = ovf_q;
  assign err_out   = err_q;

endmodule

// File: tb/tb_conv_core_v2.sv
// tb_conv_core_v2: directed bench for conv_core_v2.
// Models X/Y sync-read RAMs and captures Z writes.
module tb_conv_core_v2;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int ZW = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [2*AW+1:0] cfg = '0;
  logic [DW-1:0]   dataX = '0;
  logic [DW-1:0]   dataY = '0;
  logic [AW-1:0]   memX_addr, memY_addr;
  logic [ZW-1:0]   dataZ;
  logic [AW:0]     memZ_addr;
  logic            writeZ, busy_out, done_out, ovf_out, err_out;

  conv_core_v2 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZW(ZW)) dut (
    .clk(clk), .rst(rst), .start(start), .config_in(cfg),
    .dataX(dataX), .memX_addr(memX_addr),
    .dataY(dataY), .memY_addr(memY_addr),
    .dataZ(dataZ), .memZ_addr(memZ_addr), .writeZ(writeZ),
    .busy_out(busy_out), .done_out(done_out),
    .ovf_out(ovf_out), .err_out(err_out)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] xm [0:31];
  logic [DW-1:0] ym [0:31];
  logic [ZW-1:0] zm [0:63];

  always @(posedge clk) begin
    dataX <= xm[memX_addr];
    dataY <= ym[memY_addr];
  end

  int total = 0;
  int bad   = 0;
  int nwr, ndone, dcyc, aact;

  task automatic load_basic();
    for (int i = 0; i < 32; i++) begin
      xm[i] = (i < 5) ? DW'(i + 1) : '0;
      ym[i] = (i < 10) ? DW'(1) : '0;
    end
  endtask

  task automatic run(input int sx, input int sy, input bit sg,
                     input bit st, input int start_at);
    logic [AW-1:0] a, b;
    a = sx[AW-1:0];
    b = sy[AW-1:0];
    for (int i = 0; i < 64; i++) zm[i] = 64'hA5A5_A5A5_A5A5_A5A5;
    nwr = 0; ndone = 0; dcyc = -1; aact = 0;
    @(negedge clk);
    cfg = {st, sg, b, a};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n < 3000; n++) begin
      if (writeZ) begin
        zm[memZ_addr] = dataZ;
        nwr++;
      end
      if (done_out) begin
        ndone++;
        if (dcyc < 0) dcyc = n;
      end
      if (memX_addr != '0 || memY_addr != '0) aact++;
      if (dcyc >= 0 && n >= dcyc + 3) break;
      start = (n == start_at);
      @(negedge clk);
    end
    start = 1'b0;
    total++;
    if (dcyc < 0) begin
      $display("FAIL run_timeout got=no_done exp=done");
      bad++;
    end
  endtask

  task automatic check_basic(input string tag);
    logic [ZW-1:0] e [14];
    e = '{1, 3, 6, 10, 15, 15, 15, 15, 15, 15, 14, 12, 9, 5};
    for (int i = 0; i < 14; i++) begin
      total++;
      if (zm[i] !== e[i]) begin
        $display("FAIL %s_z%0d got=%h exp=%h", tag, i, zm[i], e[i]);
        bad++;
      end
    end
    total++;
    if (nwr !== 14) begin
      $display("FAIL %s_nwr got=%0d exp=14", tag, nwr); bad++;
    end
    total++;
    if (dcyc !== 94) begin
      $display("FAIL %s_done_cyc got=%0d exp=94", tag, dcyc); bad++;
    end
    total++;
    if (ndone !== 1) begin
      $display("FAIL %s_ndone got=%0d exp=1", tag, ndone); bad++;
    end
    total++;
    if (ovf_out !== 1'b0 || err_out !== 1'b0) begin
      $display("FAIL %s_flags got=%b%b exp=00", tag, ovf_out, err_out);
      bad++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({memX_addr, memY_addr, memZ_addr, dataZ} !== '0) begin
      $display("FAIL reset_bus got=%h exp=0",
               {memX_addr, memY_addr, memZ_addr, dataZ});
      bad++;
    end
    total++;
    if ({writeZ, busy_out, done_out, ovf_out, err_out} !== 5'b0) begin
      $display("FAIL reset_ctl got=%b exp=00000",
               {writeZ, busy_out, done_out, ovf_out, err_out});
      bad++;
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    load_basic();
    run(5, 10, 1'b0, 1'b0, -1);
    check_basic("basic");
  endtask

  task automatic load_sgn();
    for (int i = 0; i < 32; i++) begin xm[i] = '0; ym[i] = '0; end
    xm[0] = 32'hFFFF_FFFF;
    ym[0] = 32'd3;
    ym[1] = 32'hFFFF_FFFE;
  endtask

  task automatic test_signed();
    load_sgn();
    run(1, 2, 1'b1, 1'b0, -1);
    total++;
    if (zm[0] !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      $display("FAIL sgn_z0 got=%h exp=fffffffffffffffd", zm[0]); bad++;
    end
    total++;
    if (zm[1] !== 64'h2) begin
      $display("FAIL sgn_z1 got=%h exp=2", zm[1]); bad++;
    end
    total++;
    if (dcyc !== 10 || nwr !== 2 || ovf_out !== 1'b0) begin
      $display("FAIL sgn_meta got=%0d/%0d/%b exp=10/2/0",
               dcyc, nwr, ovf_out);
      bad++;
    end
    run(1, 2, 1'b0, 1'b0, -1);
    total++;
    if (zm[0] !== 64'h0000_0002_FFFF_FFFD) begin
      $display("FAIL uns_z0 got=%h exp=00000002fffffffd", zm[0]); bad++;
    end
    total++;
    if (zm[1] !== 64'hFFFF_FFFD_0000_0002) begin
      $display("FAIL uns_z1 got=%h exp=fffffffd00000002", zm[1]); bad++;
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 32; i++) begin xm[i] = '0; ym[i] = '0; end
    xm[0] = '1; xm[1] = '1; ym[0] = '1; ym[1] = '1;
    for (int s = 0; s < 2; s++) begin
      run(2, 2, 1'b0, s[0], -1);
      total++;
      if (zm[0] !== 64'hFFFF_FFFE_0000_0001) begin
        $display("FAIL ovf%0d_z0 got=%h exp=fffffffe00000001", s, zm[0]);
        bad++;
      end
      total++;
      if (zm[1] !== (s == 0 ? 64'hFFFF_FFFC_0000_0002 : '1)) begin
        $display("FAIL ovf%0d_z1 got=%h exp=%h", s, zm[1],
                 (s == 0 ? 64'hFFFF_FFFC_0000_0002 : 64'hFFFF_FFFF_FFFF_FFFF));
        bad++;
      end
      total++;
      if (zm[2] !== 64'hFFFF_FFFE_0000_0001) begin
        $display("FAIL ovf%0d_z2 got=%h exp=fffffffe00000001", s, zm[2]);
        bad++;
      end
      total++;
      if (ovf_out !== 1'b1) begin
        $display("FAIL ovf%0d_flag got=%b exp=1", s, ovf_out); bad++;
      end
    end
    xm[0] = 32'h8000_0000; xm[1] = 32'h8000_0000;
    ym[0] = 32'h8000_0000; ym[1] = 32'h8000_0000;
    for (int s = 0; s < 2; s++) begin
      run(2, 2, 1'b1, s[0], -1);
      total++;
      if (zm[0] !== 64'h4000_0000_0000_0000) begin
        $display("FAIL ssat%0d_z0 got=%h exp=4000000000000000", s, zm[0]);
        bad++;
      end
      total++;
      if (zm[1] !== (s == 0 ? 64'h8000_0000_0000_0000
                            : 64'h7FFF_FFFF_FFFF_FFFF)) begin
        $display("FAIL ssat%0d_z1 got=%h exp=%h", s, zm[1],
                 (s == 0 ? 64'h8000_0000_0000_0000
                         : 64'h7FFF_FFFF_FFFF_FFFF));
        bad++;
      end
      total++;
      if (ovf_out !== 1'b1) begin
        $display("FAIL ssat%0d_flag got=%b exp=1", s, ovf_out); bad++;
      end
    end
  endtask

  task automatic test_zero_size();
    run(0, 4, 1'b0, 1'b0, -1);
    total++;
    if (nwr !== 0 || aact !== 0) begin
      $display("FAIL zero_activity got=%0d/%0d exp=0/0", nwr, aact);
      bad++;
    end
    total++;
    if (err_out !== 1'b1) begin
      $display("FAIL zero_err got=%b exp=1", err_out); bad++;
    end
    total++;
    if (dcyc !== 2 || ndone !== 1) begin
      $display("FAIL zero_done got=%0d/%0d exp=2/1", dcyc, ndone); bad++;
    end
    load_sgn();
    run(1, 2, 1'b1, 1'b0, -1);
    total++;
    if (err_out !== 1'b0 || zm[1] !== 64'h2) begin
      $display("FAIL zero_recover got=%b/%h exp=0/2", err_out, zm[1]);
      bad++;
    end
  endtask

  task automatic test_start_busy();
    load_basic();
    run(5, 10, 1'b0, 1'b0, 20);
    check_basic("busy_start");
  endtask

  task automatic test_reset_midrun();
    int wr, dn;
    load_basic();
    @(negedge clk);
    cfg = {1'b0, 1'b0, 5'd10, 5'd5};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    total++;
    if (busy_out !== 1'b1) begin
      $display("FAIL mid_busy got=%b exp=1", busy_out); bad++;
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({busy_out, writeZ, done_out} !== 3'b0 ||
        memX_addr !== '0 || memY_addr !== '0) begin
      $display("FAIL mid_rst got=%b%b%b/%h/%h exp=000/0/0",
               busy_out, writeZ, done_out, memX_addr, memY_addr);
      bad++;
    end
    rst = 1'b0;
    wr = 0; dn = 0;
    repeat (100) begin
      @(negedge clk);
      if (writeZ) wr++;
      if (done_out) dn++;
    end
    total++;
    if (wr !== 0 || dn !== 0) begin
      $display("FAIL mid_quiet got=%0d/%0d exp=0/0", wr, dn); bad++;
    end
    run(5, 10, 1'b0, 1'b0, -1);
    check_basic("restart");
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin xm[i] = '0; ym[i] = '0; end
    test_reset();
    test_basic();
    test_signed();
    test_overflow();
    test_zero_size();
    test_start_busy();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_core_v2.md
Name:
conv_core_v2

Overview:
Parametrised second-generation 1-D linear convolution coprocessor core. It computes Z[k] = sum over i of X[i]*Y[k-i], for k = 0..sizeX+sizeY-2. Operands are read from two external synchronous-read RAMs (X, Y) with 1-cycle read latency. Results are written to a double-width Z RAM. Additions over the first generation:
- signed/unsigned operand mode
- parametrised result width with truncate or saturate mode
- sticky overflow flag
- zero-size error detection

Parameters:
DATA_WIDTH, 32, operand width of X and Y words
ADDR_WIDTH, 5, X/Y address width; max sizeX/sizeY = 2^ADDR_WIDTH-1
ZW, 64, Z word width; must be >= 2*DATA_WIDTH
ACC_W, 2*DATA_WIDTH+ADDR_WIDTH, internal accumulator width (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle start request, sampled only in IDLE
config_in  in  2*ADDR_WIDTH+2  [AW-1:0]=sizeX, [2AW-1:AW]=sizeY, [2AW]=signed_mode, [2AW+1]=sat_mode
dataX  in  DATA_WIDTH  X RAM read data (valid 1 cycle after memX_addr)
memX_addr  out  ADDR_WIDTH  X RAM read address
dataY  in  DATA_WIDTH  Y RAM read data (valid 1 cycle after memY_addr)
memY_addr  out  ADDR_WIDTH  Y RAM read address
dataZ  out  ZW  result word
memZ_addr  out  ADDR_WIDTH+1  Z RAM write address
writeZ  out  1  Z RAM write enable
busy_out  out  1  run in progress
done_out  out  1  one-cycle completion pulse
ovf_out  out  1  sticky: some Z value exceeded ZW range in the last run
err_out  out  1  last run was rejected because sizeX=0 or sizeY=0

Behaviour:
- Reset (synchronous, active-high) values:
  - state=IDLE.
  - All outputs 0: memX_addr, memY_addr, memZ_addr, dataZ, writeZ, busy_out, done_out, ovf_out, err_out.
  - rst asserted mid-run aborts the run on the next edge. No further writeZ. Partial Z contents are left untouched.
- FSM states: IDLE, SETUP, ISSUE, DRAIN1, DRAIN2, WRITE, DONE.
- IDLE:
  - start=1 -> SETUP.
  - start is ignored in every state other than IDLE.
- SETUP (busy_out=1):
  - Latch config_in. Clear ovf_out and err_out. Set k=0.
  - If sizeX=0 or sizeY=0: set err_out=1 -> DONE.
  - Otherwise -> ISSUE.
- ISSUE:
  - i runs from lo=max(0,k-sizeY+1) to hi=min(k,sizeX-1), one pair per cycle.
  - Drive memX_addr=i and memY_addr=k-i, for N_k=hi-lo+1 cycles.
  - Accumulator is cleared when the first pair of output k is issued.
  - Then -> DRAIN1.
- MAC pipeline:
  - Data returns 1 cycle after its address.
  - Product is registered the next cycle, then added into acc.
  - DRAIN1 and DRAIN2 flush the last pair.
- WRITE:
  - writeZ=1, memZ_addr=k, dataZ=formatted acc.
  - If k=sizeX+sizeY-2 -> DONE. Otherwise k++ -> ISSUE.
- DONE: done_out=1 for exactly one cycle, busy_out=0 -> IDLE.
- busy_out is high in SETUP through WRITE.
- memX_addr and memY_addr are held at 0 outside ISSUE. writeZ=0 outside WRITE.
- Arithmetic:
  - signed_mode=1: operands are two's complement; product and acc are signed.
  - signed_mode=0: operands, product and acc are unsigned.
  - acc is ACC_W wide and never overflows internally.
- Formatting of acc into dataZ:
  - sat_mode=0: dataZ = low ZW bits of acc.
  - sat_mode=1: clamp acc to the ZW range (unsigned [0,2^ZW-1] or signed [-2^(ZW-1),2^(ZW-1)-1]).
  - In either mode, set ovf_out if acc lies outside the ZW range.
- Latency: done_out is high in cycle 1+sizeX*sizeY+3*(sizeX+sizeY-1)+1 after the edge that samples start. Example: sizeX=5, sizeY=10 -> cycle 94. Zero-size case -> cycle 2.

Test Plan:
- Basic run, unsigned, sat=0: X=[1,2,3,4,5], Y=ten 1s, sizeX=5, sizeY=10 -> required response:
  - Z[0..13] = 1,3,6,10,15,15,15,15,15,15,14,12,9,5.
  - 14 writeZ pulses.
  - done_out in cycle 94, single pulse.
  - ovf_out=0, err_out=0.
- Signed vs unsigned: X=[0xFFFFFFFF], Y=[3,0xFFFFFFFE], sizeX=1, sizeY=2:
  - signed -> Z = 0xFFFFFFFFFFFFFFFD, 0x0000000000000002.
  - unsigned -> Z[0] = 0x00000002FFFFFFFD.
- Overflow: unsigned, X=Y=[0xFFFFFFFF,0xFFFFFFFF]:
  - Z[0] = 0xFFFFFFFE00000001 in both modes.
  - Z[1] = 0xFFFFFFFC00000002 with sat=0, and 0xFFFFFFFFFFFFFFFF with sat=1.
  - ovf_out=1 in both modes.
- Zero size: sizeX=0, sizeY=4 -> no writeZ, no address activity, err_out=1, done_out in cycle 2. A following valid run clears err_out.
- Start while busy: pulse start at cycle 20 of the basic run -> ignored; results and done timing identical to the basic run.
- Reset mid-run: rst=1 at cycle 30 of the basic run -> next cycle busy_out=0, writeZ=0, addresses 0, no done_out. A restart then reproduces the basic run exactly.
